// File: rtl/float_to_fixed_normalizer_pkg.sv
// Shared constants, state encoding and saturation helper for the float-to-fixed normalizer.
package float_to_fixed_normalizer_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS = 127;
    localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_SHIFT,
        ST_ROUND,
        ST_SIGN,
        ST_DONE
    } state_t;

    // Largest magnitude representable for the given sign; as a bit pattern it is also the
    // saturated result word (0x80..0 for negative, 0x7F..F for positive).
    function automatic logic [63:0] sat_limit(input logic neg, input int w);
        logic [63:0] one;
        one = 64'd1 << (w - 1);
        return neg ? one : one - 64'd1;
    endfunction

endpackage

// File: rtl/float_to_fixed_normalizer_shifter.sv
// Combinational bidirectional shift of the 24-bit significand with guard/sticky capture.
module fxp_barrel_shifter #(
    parameter int W = 32
) (
    input  logic [23:0]       m24,
    input  logic signed [9:0] sh,
    output logic [W:0]        mag,
    output logic              guard,
    output logic              sticky
);

    logic [W:0]  lext;
    logic [9:0]  rsh;
    logic [49:0] rext;

    always_comb begin
        lext   = (W+1)'(m24) << $unsigned(sh);
        rsh    = $unsigned(-sh);
        // Significand sits above a 26-bit field so the guard and sticky bits fall out directly.
        rext   = {m24, 26'b0} >> rsh;
        mag    = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        if (!sh[9]) begin
            mag = lext;
        end else if (rsh > 10'd25) begin
            sticky = 1'b1;
        end else begin
            mag    = (W+1)'(rext[49:26]);
            guard  = rext[25];
            sticky = |rext[24:0];
        end
    end

endmodule

// File: rtl/float_to_fixed_normalizer.sv
// IEEE-754 single to signed Q(W-FRAC).FRAC conversion with power-of-two prescale,
// round-half-away-from-zero and saturation, sequenced by a six-state FSM.
module float_to_fixed_normalizer
    import float_to_fixed_normalizer_pkg::*;
#(
    parameter int W         = 32,
    parameter int FRAC      = 16,
    parameter int SCALE_EXP = 0
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [31:0]  FLOAT,
    input  logic         Begin_FSM_FF,
    output logic         ACK_FF,
    output logic [W-1:0] RESULT,
    output logic         OVF,
    output logic         UNF
);

    localparam logic signed [9:0] SH_OFS = 10'(SCALE_EXP + FRAC - MAN_W - BIAS);
    // Exactly 2^(W-1) must still fit so the most negative value converts without overflow.
    localparam logic signed [9:0] SH_MAX = 10'(W - 24);

    state_t state, state_nxt;

    logic [31:0]       float_q;
    logic signed [9:0] sh_q;
    logic              zero_q, tiny_q, inf_q, nan_q;
    logic [W:0]        mag_q;
    logic              guard_q, lost_q, ovf_q;

    logic signed [9:0] sh_c;
    logic [W:0]        sh_mag, mag_rnd, lim;
    logic              sh_guard, sh_sticky;
    logic [EXP_W-1:0]  exp_f;
    logic [MAN_W-1:0]  man_f;

    assign exp_f   = float_q[MAN_W +: EXP_W];
    assign man_f   = float_q[MAN_W-1:0];
    assign sh_c    = $signed({2'b00, exp_f}) + SH_OFS;
    assign lim     = (W+1)'(sat_limit(float_q[31], W));
    assign mag_rnd = mag_q + {{W{1'b0}}, guard_q};
    assign ACK_FF  = (state == ST_DONE);

    fxp_barrel_shifter #(.W(W)) u_shifter (
        .m24    ({1'b1, man_f}),
        .sh     (sh_q),
        .mag    (sh_mag),
        .guard  (sh_guard),
        .sticky (sh_sticky)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (Begin_FSM_FF) state_nxt = ST_UNPACK;
            ST_UNPACK: state_nxt = ST_SHIFT;
            ST_SHIFT:  state_nxt = ST_ROUND;
            ST_ROUND:  state_nxt = ST_SIGN;
            ST_SIGN:   state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            float_q <= '0;
            sh_q    <= '0;
            zero_q  <= 1'b0;
            tiny_q  <= 1'b0;
            inf_q   <= 1'b0;
            nan_q   <= 1'b0;
            mag_q   <= '0;
            guard_q <= 1'b0;
            lost_q  <= 1'b0;
            ovf_q   <= 1'b0;
            RESULT  <= '0;
            OVF     <= 1'b0;
            UNF     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (Begin_FSM_FF) float_q <= FLOAT;
                ST_UNPACK: begin
                    sh_q   <= sh_c;
                    zero_q <= (exp_f == '0);
                    tiny_q <= (exp_f == '0) && (man_f != '0);
                    inf_q  <= (exp_f == EXP_INF) && (man_f == '0);
                    nan_q  <= (exp_f == EXP_INF) && (man_f != '0);
                end
                ST_SHIFT: begin
                    if (zero_q || inf_q || nan_q) begin
                        mag_q   <= '0;
                        guard_q <= 1'b0;
                        lost_q  <= 1'b0;
                        ovf_q   <= inf_q || nan_q;
                    end else begin
                        mag_q   <= sh_mag;
                        guard_q <= sh_guard;
                        lost_q  <= sh_guard || sh_sticky;
                        ovf_q   <= (sh_q > SH_MAX) || (sh_mag > lim);
                    end
                end
                ST_ROUND: begin
                    mag_q <= mag_rnd;
                    if (mag_rnd > lim) ovf_q <= 1'b1;
                end
                ST_SIGN: begin
                    if (ovf_q) begin
                        RESULT <= nan_q ? '0 : W'(sat_limit(float_q[31], W));
                        OVF    <= 1'b1;
                        UNF    <= 1'b0;
                    end else begin
                        RESULT <= float_q[31] ? -mag_q[W-1:0] : mag_q[W-1:0];
                        OVF    <= 1'b0;
                        UNF    <= (mag_q == '0) && (tiny_q || lost_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_fixed_normalizer.sv
// Directed-vector bench for float_to_fixed_normalizer (SCALE_EXP=0 and SCALE_EXP=-2 instances).
module tb_float_to_fixed_normalizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] float_a = '0, float_b = '0;
    logic        begin_a = 1'b0, begin_b = 1'b0;
    logic        ack_a, ack_b, ovf_a, ovf_b, unf_a, unf_b;
    logic [31:0] result_a, result_b;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    float_to_fixed_normalizer #(.W(32), .FRAC(16), .SCALE_EXP(0)) dut_a (
        .CLK(clk), .RST_N(rst_n), .FLOAT(float_a), .Begin_FSM_FF(begin_a),
        .ACK_FF(ack_a), .RESULT(result_a), .OVF(ovf_a), .UNF(unf_a)
    );

    float_to_fixed_normalizer #(.W(32), .FRAC(16), .SCALE_EXP(-2)) dut_b (
        .CLK(clk), .RST_N(rst_n), .FLOAT(float_b), .Begin_FSM_FF(begin_b),
        .ACK_FF(ack_b), .RESULT(result_b), .OVF(ovf_b), .UNF(unf_b)
    );

    // Drives one start pulse; lat counts cycles after the accepting edge (UNPACK = 1).
    task automatic run_conv(input bit sel, input logic [31:0] f, output logic [31:0] res,
                            output logic ovf, output logic unf, output int lat,
                            output logic ack_after);
        @(negedge clk);
        if (sel) begin float_b = f; begin_b = 1'b1; end
        else     begin float_a = f; begin_a = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        begin_a = 1'b0;
        begin_b = 1'b0;
        lat = 1;
        while (!(sel ? ack_b : ack_a) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = sel ? result_b : result_a;
        ovf = sel ? ovf_b : ovf_a;
        unf = sel ? unf_b : unf_a;
        @(negedge clk);
        ack_after = sel ? ack_b : ack_a;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({ack_a, result_a, ovf_a, unf_a} !== 35'd0) begin
            errors++;
            $display("FAIL reset_a: ack=%b result=%h ovf=%b unf=%b, required all 0", ack_a, result_a, ovf_a, unf_a);
        end
        checks++;
        if ({ack_b, result_b, ovf_b, unf_b} !== 35'd0) begin
            errors++;
            $display("FAIL reset_b: ack=%b result=%h ovf=%b unf=%b, required all 0", ack_b, result_b, ovf_b, unf_b);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_values();
        logic [31:0] vin [14] = '{32'h3F800000, 32'hC0200000, 32'hC7000000, 32'h47800000,
                                  32'hFF800000, 32'h7FC00000, 32'h37000000, 32'h36800000,
                                  32'h00000001, 32'h80000000, 32'hC7000001, 32'h47000000,
                                  32'hB7000000, 32'h3F800040};
        logic [31:0] vres [14] = '{32'h00010000, 32'hFFFD8000, 32'h80000000, 32'h7FFFFFFF,
                                   32'h80000000, 32'h00000000, 32'h00000001, 32'h00000000,
                                   32'h00000000, 32'h00000000, 32'h80000000, 32'h7FFFFFFF,
                                   32'hFFFFFFFF, 32'h00010001};
        logic vovf [14] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0};
        logic vunf [14] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        logic [31:0] res;
        logic ovf, unf, ack_after;
        int lat;
        for (int i = 0; i < 14; i++) begin
            run_conv(1'b0, vin[i], res, ovf, unf, lat, ack_after);
            checks++;
            if (lat !== 5) begin
                errors++;
                $display("FAIL latency %h: ack cycle %0d, required 5", vin[i], lat);
            end
            checks++;
            if (ack_after !== 1'b0) begin
                errors++;
                $display("FAIL ack_width %h: ack after done=%b, required 0", vin[i], ack_after);
            end
            checks++;
            if (res !== vres[i]) begin
                errors++;
                $display("FAIL result %h: got %h, required %h", vin[i], res, vres[i]);
            end
            checks++;
            if (ovf !== vovf[i] || unf !== vunf[i]) begin
                errors++;
                $display("FAIL flags %h: ovf=%b unf=%b, required ovf=%b unf=%b", vin[i], ovf, unf, vovf[i], vunf[i]);
            end
        end
    endtask

    task automatic test_scale();
        logic [31:0] res;
        logic ovf, unf, ack_after;
        int lat;
        run_conv(1'b1, 32'h40800000, res, ovf, unf, lat, ack_after);
        checks++;
        if (res !== 32'h00010000 || ovf !== 1'b0 || unf !== 1'b0 || lat !== 5) begin
            errors++;
            $display("FAIL scale_4p0: result=%h ovf=%b unf=%b lat=%0d, required 00010000 0 0 5", res, ovf, unf, lat);
        end
        run_conv(1'b1, 32'h3F800000, res, ovf, unf, lat, ack_after);
        checks++;
        if (res !== 32'h00004000 || ovf !== 1'b0 || unf !== 1'b0) begin
            errors++;
            $display("FAIL scale_1p0: result=%h ovf=%b unf=%b, required 00004000 0 0", res, ovf, unf);
        end
    endtask

    task automatic test_busy_ignore();
        int acks = 0;
        logic [31:0] res = '0;
        @(negedge clk);
        float_a = 32'h3F800000;
        begin_a = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (ack_a) begin
                acks++;
                res = result_a;
            end
            begin_a = (n == 1 || n == 3);
            if (n == 1) float_a = 32'h40000000;
        end
        checks++;
        if (acks !== 1) begin
            errors++;
            $display("FAIL busy_ack_count: got %0d acks, required 1", acks);
        end
        checks++;
        if (res !== 32'h00010000) begin
            errors++;
            $display("FAIL busy_result: got %h, required 00010000", res);
        end
    endtask

    task automatic test_back_to_back();
        int first = 0, second = 0;
        logic [31:0] r1 = '0, r2 = '0;
        @(negedge clk);
        float_a = 32'h3F800000;
        begin_a = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (ack_a) begin
                if (first == 0) begin
                    first = n;
                    r1 = result_a;
                    float_a = 32'hC0200000;
                end else if (second == 0) begin
                    second = n;
                    r2 = result_a;
                    begin_a = 1'b0;
                end
            end
        end
        begin_a = 1'b0;
        checks++;
        if (first !== 5 || second !== 11) begin
            errors++;
            $display("FAIL b2b_timing: acks at cycles %0d and %0d, required 5 and 11", first, second);
        end
        checks++;
        if (r1 !== 32'h00010000 || r2 !== 32'hFFFD8000) begin
            errors++;
            $display("FAIL b2b_results: got %h %h, required 00010000 FFFD8000", r1, r2);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] res;
        logic ovf, unf, ack_after;
        int lat;
        int acks = 0;
        run_conv(1'b0, 32'h47800000, res, ovf, unf, lat, ack_after);
        @(negedge clk);
        float_a = 32'hC0200000;
        begin_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        begin_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (result_a !== 32'h0 || ovf_a !== 1'b0 || unf_a !== 1'b0 || ack_a !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: result=%h ovf=%b unf=%b ack=%b, required 0", result_a, ovf_a, unf_a, ack_a);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (ack_a) acks++;
        end
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("FAIL abort_no_ack: got %0d acks, required 0", acks);
        end
        run_conv(1'b0, 32'h3F800000, res, ovf, unf, lat, ack_after);
        checks++;
        if (res !== 32'h00010000 || ovf !== 1'b0 || unf !== 1'b0 || lat !== 5) begin
            errors++;
            $display("FAIL abort_recover: result=%h ovf=%b unf=%b lat=%0d, required 00010000 0 0 5", res, ovf, unf, lat);
        end
    endtask

    initial begin
        test_reset();
        test_values();
        test_scale();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
